// File: rtl/lbus_axis_400g_pkg.sv
// Shared constants and FSM state type for the 400G LBUS RX to AXIS bridge.
package lbus_axis_400g_pkg;

    localparam int C_SEGMENTS      = 8;
    localparam int C_SEGMENT_BYTES = 16;
    localparam int C_SEGMENT_BITS  = C_SEGMENT_BYTES * 8;
    localparam int C_MTY_WIDTH     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        INPKT = 1'b1
    } state_t;

endpackage

// File: rtl/lbus_rx_segment_map.sv
// One LBUS segment: byte reversal into AXIS little-endian order plus a 16-bit keep.
module lbus_rx_segment_map
    import lbus_axis_400g_pkg::*;
(
    input  logic [C_SEGMENT_BITS-1:0]  data,
    input  logic                       ena,
    input  logic                       eop,
    input  logic [C_MTY_WIDTH-1:0]     mty,
    output logic [C_SEGMENT_BITS-1:0]  data_swapped,
    output logic [C_SEGMENT_BYTES-1:0] keep
);

    // LBUS byte 0 sits in the top bits; AXIS byte 0 sits in the bottom bits.
    always_comb begin
        data_swapped = '0;
        for (int j = 0; j < C_SEGMENT_BYTES; j++) begin
            data_swapped[8*j +: 8] = data[C_SEGMENT_BITS-1-8*j -: 8];
        end
    end

    // mty only trims the end-of-packet segment.
    assign keep = !ena ? '0 :
                  eop  ? ({C_SEGMENT_BYTES{1'b1}} >> mty) :
                         {C_SEGMENT_BYTES{1'b1}};

endmodule

// File: rtl/lbus_rx_axis_tx_400g.sv
// 8-segment LBUS RX to 1024-bit AXIS master; one-cycle registered latency, no back-pressure.
module lbus_rx_axis_tx_400g
    import lbus_axis_400g_pkg::*;
#(
    parameter int G_AXIS_DATA_WIDTH = 1024,
    parameter int G_LENGTH_WIDTH    = 16
) (
    input  logic                           lbus_rxclk,
    input  logic                           lbus_rxresetn,

    input  logic [127:0]                   lbus_rxdatain0,
    input  logic [127:0]                   lbus_rxdatain1,
    input  logic [127:0]                   lbus_rxdatain2,
    input  logic [127:0]                   lbus_rxdatain3,
    input  logic [127:0]                   lbus_rxdatain4,
    input  logic [127:0]                   lbus_rxdatain5,
    input  logic [127:0]                   lbus_rxdatain6,
    input  logic [127:0]                   lbus_rxdatain7,
    input  logic                           lbus_rxenain0,
    input  logic                           lbus_rxenain1,
    input  logic                           lbus_rxenain2,
    input  logic                           lbus_rxenain3,
    input  logic                           lbus_rxenain4,
    input  logic                           lbus_rxenain5,
    input  logic                           lbus_rxenain6,
    input  logic                           lbus_rxenain7,
    input  logic                           lbus_rxsopin0,
    input  logic                           lbus_rxsopin1,
    input  logic                           lbus_rxsopin2,
    input  logic                           lbus_rxsopin3,
    input  logic                           lbus_rxsopin4,
    input  logic                           lbus_rxsopin5,
    input  logic                           lbus_rxsopin6,
    input  logic                           lbus_rxsopin7,
    input  logic                           lbus_rxeopin0,
    input  logic                           lbus_rxeopin1,
    input  logic                           lbus_rxeopin2,
    input  logic                           lbus_rxeopin3,
    input  logic                           lbus_rxeopin4,
    input  logic                           lbus_rxeopin5,
    input  logic                           lbus_rxeopin6,
    input  logic                           lbus_rxeopin7,
    input  logic                           lbus_rxerrin0,
    input  logic                           lbus_rxerrin1,
    input  logic                           lbus_rxerrin2,
    input  logic                           lbus_rxerrin3,
    input  logic                           lbus_rxerrin4,
    input  logic                           lbus_rxerrin5,
    input  logic                           lbus_rxerrin6,
    input  logic                           lbus_rxerrin7,
    input  logic [3:0]                     lbus_rxmtyin0,
    input  logic [3:0]                     lbus_rxmtyin1,
    input  logic [3:0]                     lbus_rxmtyin2,
    input  logic [3:0]                     lbus_rxmtyin3,
    input  logic [3:0]                     lbus_rxmtyin4,
    input  logic [3:0]                     lbus_rxmtyin5,
    input  logic [3:0]                     lbus_rxmtyin6,
    input  logic [3:0]                     lbus_rxmtyin7,

    output logic [G_AXIS_DATA_WIDTH-1:0]   axis_tx_tdata,
    output logic                           axis_tx_tvalid,
    output logic [G_AXIS_DATA_WIDTH/8-1:0] axis_tx_tkeep,
    output logic                           axis_tx_tlast,
    output logic                           axis_tx_tuser,
    output logic [G_LENGTH_WIDTH-1:0]      axis_tx_packet_length,
    output logic [31:0]                    protocol_error_count
);

    logic [C_SEGMENTS-1:0][C_SEGMENT_BITS-1:0]  seg_data;
    logic [C_SEGMENTS-1:0][C_SEGMENT_BITS-1:0]  seg_bytes;
    logic [C_SEGMENTS-1:0][C_SEGMENT_BYTES-1:0] seg_keep;
    logic [C_SEGMENTS-1:0][C_MTY_WIDTH-1:0]     seg_mty;
    logic [C_SEGMENTS-1:0]                      seg_ena, seg_eop, seg_err;
    logic                                       unused_sop;

    assign seg_data = {lbus_rxdatain7, lbus_rxdatain6, lbus_rxdatain5, lbus_rxdatain4,
                       lbus_rxdatain3, lbus_rxdatain2, lbus_rxdatain1, lbus_rxdatain0};
    assign seg_mty  = {lbus_rxmtyin7, lbus_rxmtyin6, lbus_rxmtyin5, lbus_rxmtyin4,
                       lbus_rxmtyin3, lbus_rxmtyin2, lbus_rxmtyin1, lbus_rxmtyin0};
    assign seg_ena  = {lbus_rxenain7, lbus_rxenain6, lbus_rxenain5, lbus_rxenain4,
                       lbus_rxenain3, lbus_rxenain2, lbus_rxenain1, lbus_rxenain0};
    assign seg_eop  = {lbus_rxeopin7, lbus_rxeopin6, lbus_rxeopin5, lbus_rxeopin4,
                       lbus_rxeopin3, lbus_rxeopin2, lbus_rxeopin1, lbus_rxeopin0};
    assign seg_err  = {lbus_rxerrin7, lbus_rxerrin6, lbus_rxerrin5, lbus_rxerrin4,
                       lbus_rxerrin3, lbus_rxerrin2, lbus_rxerrin1, lbus_rxerrin0};

    // Packets may only start in segment 0, so sop on the other segments carries no information.
    assign unused_sop = ^{lbus_rxsopin7, lbus_rxsopin6, lbus_rxsopin5, lbus_rxsopin4,
                          lbus_rxsopin3, lbus_rxsopin2, lbus_rxsopin1};

    for (genvar k = 0; k < C_SEGMENTS; k++) begin : g_seg
        lbus_rx_segment_map u_map (
            .data         (seg_data[k]),
            .ena          (seg_ena[k]),
            .eop          (seg_eop[k]),
            .mty          (seg_mty[k]),
            .data_swapped (seg_bytes[k]),
            .keep         (seg_keep[k])
        );
    end

    logic                                       has_eop;
    logic [2:0]                                 eop_idx;
    logic [C_SEGMENTS-1:0][C_SEGMENT_BYTES-1:0] keep_beat;
    logic [7:0]                                 beat_bytes;
    logic                                       err_beat;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        has_eop = 1'b0;
        eop_idx = '0;
        // Scanning downward leaves the lowest enabled eop segment as the winner.
        for (int k = C_SEGMENTS - 1; k >= 0; k--) begin
            if (seg_ena[k] && seg_eop[k]) begin
                has_eop = 1'b1;
                eop_idx = 3'(k);
            end
        end
    end

    always_comb begin
        keep_beat  = '0;
        beat_bytes = '0;
        err_beat   = 1'b0;
        for (int k = 0; k < C_SEGMENTS; k++) begin
            if (!has_eop || k <= int'(eop_idx)) begin
                keep_beat[k] = seg_keep[k];
                err_beat     = err_beat | (seg_ena[k] & seg_err[k]);
                if (seg_ena[k]) begin
                    if (has_eop && k == int'(eop_idx))
                        beat_bytes = beat_bytes + (8'(C_SEGMENT_BYTES) - 8'(seg_mty[k]));
                    else
                        beat_bytes = beat_bytes + 8'(C_SEGMENT_BYTES);
                end
            end
        end
    end

    logic [G_LENGTH_WIDTH-1:0] byte_acc;
    logic [G_LENGTH_WIDTH:0]   acc_sum;
    logic [G_LENGTH_WIDTH-1:0] acc_sat;
    logic                      sticky_err;

    assign acc_sum = {1'b0, byte_acc} + (G_LENGTH_WIDTH+1)'(beat_bytes);
    assign acc_sat = acc_sum[G_LENGTH_WIDTH] ? '1 : acc_sum[G_LENGTH_WIDTH-1:0];

    state_t state, state_next;
    logic   emit, last, bad_sop, proto_err;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge lbus_rxclk or negedge lbus_rxresetn) begin
        if (!lbus_rxresetn) state <= IDLE;
        else                state <= state_next;
    end

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        last       = 1'b0;
        bad_sop    = 1'b0;
        proto_err  = 1'b0;
        case (state)
            IDLE: begin
                if (seg_ena[0]) begin
                    if (lbus_rxsopin0) begin
                        emit = 1'b1;
                        if (has_eop) last = 1'b1;
                        else         state_next = INPKT;
                    end else begin
                        proto_err = 1'b1;
                    end
                end
            end
            INPKT: begin
                if (seg_ena[0]) begin
                    emit = 1'b1;
                    // A fresh sop inside a packet truncates the current packet as bad.
                    if (lbus_rxsopin0) begin
                        last       = 1'b1;
                        bad_sop    = 1'b1;
                        proto_err  = 1'b1;
                        state_next = IDLE;
                    end else if (has_eop) begin
                        last       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: tdata is ordinary flops rather than a RAM, so it is cleared with the other outputs.
    always_ff @(posedge lbus_rxclk or negedge lbus_rxresetn) begin
        if (!lbus_rxresetn) begin
            axis_tx_tdata         <= '0;
            axis_tx_tvalid        <= 1'b0;
            axis_tx_tkeep         <= '0;
            axis_tx_tlast         <= 1'b0;
            axis_tx_tuser         <= 1'b0;
            axis_tx_packet_length <= '0;
            protocol_error_count  <= '0;
            byte_acc              <= '0;
            sticky_err            <= 1'b0;
        end else begin
            axis_tx_tvalid <= emit;
            axis_tx_tlast  <= emit & last;
            axis_tx_tuser  <= emit & last & (sticky_err | err_beat | bad_sop);
            axis_tx_tkeep  <= emit ? keep_beat : '0;
            if (emit) axis_tx_tdata <= seg_bytes;

            if (emit && last) begin
                axis_tx_packet_length <= acc_sat;
                byte_acc              <= '0;
                sticky_err            <= 1'b0;
            end else if (emit) begin
                byte_acc   <= acc_sat;
                sticky_err <= sticky_err | err_beat;
            end

            if (proto_err && protocol_error_count != '1)
                protocol_error_count <= protocol_error_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_lbus_rx_axis_tx_400g.sv
// Directed self-checking bench for lbus_rx_axis_tx_400g; expectations are hand-computed constants.
module tb_lbus_rx_axis_tx_400g;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [127:0] d   [8];
    logic [3:0]   mty [8];
    logic [7:0]   ena, sop, eop, err;

    logic [1023:0] tdata;
    logic [127:0]  tkeep;
    logic          tvalid, tlast, tuser;
    logic [15:0]   plen;
    logic [31:0]   perr;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] KEEP_ALL = {128{1'b1}};
    localparam logic [127:0] KEEP_64  = {{64{1'b0}}, {64{1'b1}}};

    lbus_rx_axis_tx_400g dut (
        .lbus_rxclk(clk), .lbus_rxresetn(rst_n),
        .lbus_rxdatain0(d[0]), .lbus_rxdatain1(d[1]), .lbus_rxdatain2(d[2]), .lbus_rxdatain3(d[3]),
        .lbus_rxdatain4(d[4]), .lbus_rxdatain5(d[5]), .lbus_rxdatain6(d[6]), .lbus_rxdatain7(d[7]),
        .lbus_rxenain0(ena[0]), .lbus_rxenain1(ena[1]), .lbus_rxenain2(ena[2]), .lbus_rxenain3(ena[3]),
        .lbus_rxenain4(ena[4]), .lbus_rxenain5(ena[5]), .lbus_rxenain6(ena[6]), .lbus_rxenain7(ena[7]),
        .lbus_rxsopin0(sop[0]), .lbus_rxsopin1(sop[1]), .lbus_rxsopin2(sop[2]), .lbus_rxsopin3(sop[3]),
        .lbus_rxsopin4(sop[4]), .lbus_rxsopin5(sop[5]), .lbus_rxsopin6(sop[6]), .lbus_rxsopin7(sop[7]),
        .lbus_rxeopin0(eop[0]), .lbus_rxeopin1(eop[1]), .lbus_rxeopin2(eop[2]), .lbus_rxeopin3(eop[3]),
        .lbus_rxeopin4(eop[4]), .lbus_rxeopin5(eop[5]), .lbus_rxeopin6(eop[6]), .lbus_rxeopin7(eop[7]),
        .lbus_rxerrin0(err[0]), .lbus_rxerrin1(err[1]), .lbus_rxerrin2(err[2]), .lbus_rxerrin3(err[3]),
        .lbus_rxerrin4(err[4]), .lbus_rxerrin5(err[5]), .lbus_rxerrin6(err[6]), .lbus_rxerrin7(err[7]),
        .lbus_rxmtyin0(mty[0]), .lbus_rxmtyin1(mty[1]), .lbus_rxmtyin2(mty[2]), .lbus_rxmtyin3(mty[3]),
        .lbus_rxmtyin4(mty[4]), .lbus_rxmtyin5(mty[5]), .lbus_rxmtyin6(mty[6]), .lbus_rxmtyin7(mty[7]),
        .axis_tx_tdata(tdata), .axis_tx_tvalid(tvalid), .axis_tx_tkeep(tkeep),
        .axis_tx_tlast(tlast), .axis_tx_tuser(tuser),
        .axis_tx_packet_length(plen), .protocol_error_count(perr)
    );

    task automatic check(input string tag, input logic [1023:0] observed, input logic [1023:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clear_in();
        for (int k = 0; k < 8; k++) begin
            d[k]   = '0;
            mty[k] = '0;
        end
        ena = '0; sop = '0; eop = '0; err = '0;
    endtask

    // Segment k carries LBUS bytes whose value is (base + 16k + j) mod 256, byte 0 at the top.
    task automatic set_seg(input int k, input int base);
        ena[k] = 1'b1;
        for (int j = 0; j < 16; j++) d[k][127-8*j -: 8] = 8'((base + 16*k + j) & 255);
    endtask

    task automatic full_beat(input int base, input logic s, input logic e, input int err_seg);
        clear_in();
        for (int k = 0; k < 8; k++) set_seg(k, base);
        sop[0] = s;
        eop[7] = e;
        if (err_seg >= 0) err[err_seg] = 1'b1;
    endtask

    // Expected AXIS data: byte n = (base + n) mod 256 for n < nbytes, zero above.
    function automatic logic [1023:0] pattern(input int base, input int nbytes);
        logic [1023:0] p = '0;
        for (int n = 0; n < nbytes; n++) p[8*n +: 8] = 8'((base + n) & 255);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_64();
        clear_in();
        for (int k = 0; k < 4; k++) set_seg(k, 0);
        sop[0] = 1'b1;
        eop[3] = 1'b1;
        tick();
    endtask

    initial begin
        clear_in();
        #12;
        check("reset_tvalid", 1024'(tvalid), 1024'(0));
        check("reset_tlast",  1024'(tlast),  1024'(0));
        check("reset_tuser",  1024'(tuser),  1024'(0));
        check("reset_tkeep",  1024'(tkeep),  1024'(0));
        check("reset_tdata",  tdata,         1024'(0));
        check("reset_plen",   1024'(plen),   1024'(0));
        check("reset_perr",   1024'(perr),   1024'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single-beat 64-byte packet.
        send_64();
        check("p64_tvalid", 1024'(tvalid), 1024'(1));
        check("p64_tkeep",  1024'(tkeep),  1024'(KEEP_64));
        check("p64_tlast",  1024'(tlast),  1024'(1));
        check("p64_tuser",  1024'(tuser),  1024'(0));
        check("p64_plen",   1024'(plen),   1024'(64));
        check("p64_tdata",  tdata,         pattern(0, 64));
        clear_in();
        tick();
        check("idle_tvalid", 1024'(tvalid), 1024'(0));

        // 8192-byte packet as 64 full beats.
        for (int i = 0; i < 64; i++) begin
            full_beat(i * 128, i == 0, i == 63, -1);
            tick();
            check($sformatf("p8k_tvalid_%0d", i), 1024'(tvalid), 1024'(1));
            check($sformatf("p8k_tkeep_%0d", i),  1024'(tkeep),  1024'(KEEP_ALL));
            check($sformatf("p8k_tlast_%0d", i),  1024'(tlast),  1024'(i == 63));
            if (i == 0)  check("p8k_plen_hold", 1024'(plen), 1024'(64));
            if (i == 5)  check("p8k_tdata_5", tdata, pattern(5 * 128, 128));
        end
        check("p8k_tuser", 1024'(tuser), 1024'(0));
        check("p8k_plen",  1024'(plen),  1024'(8192));

        // 130-byte packet; stray mty on a non-eop segment and an eop above the first are ignored.
        full_beat(0, 1'b1, 1'b0, -1);
        mty[2] = 4'd9;
        tick();
        check("p130_b0_tkeep", 1024'(tkeep), 1024'(KEEP_ALL));
        check("p130_b0_tlast", 1024'(tlast), 1024'(0));
        clear_in();
        set_seg(0, 128);
        set_seg(1, 128);
        eop[0] = 1'b1; mty[0] = 4'd14;
        eop[1] = 1'b1; mty[1] = 4'd3;
        tick();
        check("p130_b1_tkeep", 1024'(tkeep), 1024'(128'h3));
        check("p130_b1_tlast", 1024'(tlast), 1024'(1));
        check("p130_b1_bytes", 1024'(tdata[15:0]), 1024'(16'h8180));
        check("p130_plen",     1024'(plen),  1024'(130));

        // 3-beat packet with err on segment 5 of the middle beat, plus a bubble.
        full_beat(0, 1'b1, 1'b0, -1);
        tick();
        check("err_b0_tuser", 1024'(tuser), 1024'(0));
        clear_in();
        tick();
        check("bubble_tvalid", 1024'(tvalid), 1024'(0));
        full_beat(128, 1'b0, 1'b0, 5);
        tick();
        check("err_b1_tvalid", 1024'(tvalid), 1024'(1));
        check("err_b1_tuser",  1024'(tuser),  1024'(0));
        full_beat(256, 1'b0, 1'b1, -1);
        tick();
        check("err_b2_tlast", 1024'(tlast), 1024'(1));
        check("err_b2_tuser", 1024'(tuser), 1024'(1));
        check("err_plen",     1024'(plen),  1024'(384));
        send_64();
        check("err_clear_tuser", 1024'(tuser), 1024'(0));

        // Protocol violations: non-sop in IDLE, then sop inside a packet.
        full_beat(0, 1'b0, 1'b0, -1);
        tick();
        check("nosop_tvalid", 1024'(tvalid), 1024'(0));
        check("nosop_perr",   1024'(perr),   1024'(1));
        full_beat(0, 1'b1, 1'b0, -1);
        tick();
        check("sop1_tlast", 1024'(tlast), 1024'(0));
        full_beat(128, 1'b1, 1'b0, -1);
        tick();
        check("sop2_tvalid", 1024'(tvalid), 1024'(1));
        check("sop2_tlast",  1024'(tlast),  1024'(1));
        check("sop2_tuser",  1024'(tuser),  1024'(1));
        check("sop2_perr",   1024'(perr),   1024'(2));
        check("sop2_plen",   1024'(plen),   1024'(256));
        full_beat(256, 1'b0, 1'b0, -1);
        tick();
        check("after_sop_tvalid", 1024'(tvalid), 1024'(0));
        check("after_sop_perr",   1024'(perr),   1024'(3));

        // Reset in the middle of a packet, then a clean 64-byte packet.
        full_beat(0, 1'b1, 1'b0, -1);
        tick();
        check("mid_tvalid", 1024'(tvalid), 1024'(1));
        clear_in();
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", 1024'(tvalid), 1024'(0));
        check("mid_rst_plen",   1024'(plen),   1024'(0));
        check("mid_rst_perr",   1024'(perr),   1024'(0));
        #1;
        rst_n = 1'b1;
        send_64();
        check("post_tkeep", 1024'(tkeep), 1024'(KEEP_64));
        check("post_tlast", 1024'(tlast), 1024'(1));
        check("post_tuser", 1024'(tuser), 1024'(0));
        check("post_plen",  1024'(plen),  1024'(64));
        check("post_perr",  1024'(perr),  1024'(0));
        clear_in();
        tick();
        check("post_idle_tlast", 1024'(tlast), 1024'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
